// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and default constants for the CPU data-memory bus.
package mem_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] DEF_MAILBOX_ADDR = 32'd84;
    localparam logic [DATA_W-1:0] DEF_PASS_VALUE = 32'd7;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM, synchronous write with combinational read.
module dmem_ram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        if (we) r_mem[idx] <= wdata;
    assign rdata = r_mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder with RAM and a pass/done test mailbox.
module dmem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] MAILBOX_ADDR = DEF_MAILBOX_ADDR,
    parameter logic [DATA_W-1:0] PASS_VALUE = DEF_PASS_VALUE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              done,
    output logic              pass
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OFF_W = $clog2(WORD_BYTES);
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we, r_ready, r_err, r_done, r_pass;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              w_commit, w_we, w_misal, w_mbox, w_oor, w_ram_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata, w_ram_rdata;
    // With zero wait states the accepting edge is also the commit edge, so decode sees the live inputs.
    assign w_commit = (r_state == IDLE && req && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd1);
    assign w_we     = (r_state == IDLE) ? we : r_we;
    assign w_addr   = (r_state == IDLE) ? addr : r_addr;
    assign w_wdata  = (r_state == IDLE) ? wdata : r_wdata;
    assign w_misal  = w_addr[OFF_W-1:0] != '0;
    assign w_mbox   = w_addr == MAILBOX_ADDR;
    assign w_oor    = w_addr[ADDR_W-1:OFF_W] >= (ADDR_W-OFF_W)'(DEPTH_WORDS);
    assign w_ram_we = w_commit && w_we && !w_misal && !w_mbox && !w_oor;
    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .idx   (w_addr[OFF_W +: IDX_W]),
        .wdata (w_wdata),
        .rdata (w_ram_rdata)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_ready <= w_commit;
            case (r_state)
                IDLE: if (req) begin
                    r_we    <= we;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_cnt   <= 4'(WAIT_CYCLES);
                    r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
            if (w_commit) begin
                r_err   <= w_misal || (!w_mbox && w_oor);
                r_rdata <= (w_misal || w_we) ? '0 :
                           w_mbox ? {{(DATA_W-2){1'b0}}, r_pass, r_done} :
                           w_oor ? '0 : w_ram_rdata;
                if (w_we && !w_misal && w_mbox) begin
                    r_done <= 1'b1;
                    r_pass <= w_wdata == PASS_VALUE;
                end
            end
        end
    end
    assign ready = r_ready;
    assign rdata = r_rdata;
    assign err   = r_err;
    assign done  = r_done;
    assign pass  = r_pass;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of two responders (2 and 0 wait states).
module tb_dmem_responder;
    import mem_bus_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err [2];
    logic        done [2];
    logic        pass [2];
    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .done(done[0]), .pass(pass[0])
    );
    dmem_responder #(.WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .done(done[1]), .pass(pass[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int passed = 0, total = 0;
    logic [31:0] mem [2][64];
    bit          vld [2][64];
    bit          mdone [2], mpass [2], at_resp [2], chained [2];
    int          last_rdy [2];

    function automatic int lat(int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One transaction on instance u; the model result is derived from the address rules first.
    task automatic tx(int u, bit w, logic [31:0] a, logic [31:0] d, bit drop, bit chain);
        logic [31:0] er;
        bit ee, kn, mb_st;
        int n;
        string p;
        p = (u == 0) ? "a_" : "b_";
        er = 0; ee = 0; kn = 1; mb_st = 0;
        if (a % 4 != 0) ee = 1;
        else if (a == 84) begin
            if (w) begin mdone[u] = 1; mpass[u] = (d == 7); mb_st = 1; end
            else er = {30'b0, mpass[u], mdone[u]};
        end
        else if (a / 4 >= 64) ee = 1;
        else if (w) begin mem[u][a/4] = d; vld[u][a/4] = 1; end
        else begin er = mem[u][a/4]; kn = vld[u][a/4]; end
        we[u] = w; addr[u] = a; wdata[u] = d; req[u] = 1;
        if (at_resp[u]) @(posedge clk);
        @(posedge clk); #1;
        if (drop) req[u] = 0;
        n = 1;
        while (!ready[u] && n < 20) begin @(posedge clk); #1; n++; end
        chk({p, "latency"}, n, lat(u) + 1);
        if (chained[u]) chk({p, "spacing"}, cyc - last_rdy[u], lat(u) + 2);
        last_rdy[u] = cyc;
        chained[u] = chain;
        chk({p, "err"}, err[u], ee);
        if (kn && !mb_st) chk({p, "rdata"}, rdata[u], er);
        chk({p, "done"}, done[u], mdone[u]);
        chk({p, "pass"}, pass[u], mpass[u]);
        if (chain) at_resp[u] = 1;
        else begin
            req[u] = 0;
            @(posedge clk); #1;
            chk({p, "pulse"}, ready[u], 0);
            at_resp[u] = 0;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mdone[u] = 0; mpass[u] = 0; at_resp[u] = 0; chained[u] = 0;
        end
    endtask

    initial begin
        int extra;
        logic [31:0] a, d;
        bit w;
        for (int u = 0; u < 2; u++) begin
            req[u] = 0; we[u] = 0; addr[u] = 0; wdata[u] = 0;
        end
        model_reset();
        rst_n = 0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", ready[u], 0);
            chk("rst_err", err[u], 0);
            chk("rst_rdata", rdata[u], 0);
            chk("rst_done", done[u], 0);
            chk("rst_pass", pass[u], 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        // Store then held-request load, 2 wait states.
        tx(0, 1, 32'h10, 32'hDEADBEEF, 0, 1);
        tx(0, 0, 32'h10, 0, 0, 0);
        // Zero wait states, request held across all six accesses.
        tx(1, 1, 32'h0, 1, 0, 1);
        tx(1, 1, 32'h4, 2, 0, 1);
        tx(1, 1, 32'h8, 3, 0, 1);
        tx(1, 0, 32'h0, 0, 0, 1);
        tx(1, 0, 32'h4, 0, 0, 1);
        tx(1, 0, 32'h8, 0, 0, 0);
        // Mailbox pass, then fail, then readback.
        for (int u = 0; u < 2; u++) begin
            tx(u, 1, 84, 7, 0, 0);
            tx(u, 1, 84, 5, 0, 0);
            tx(u, 0, 84, 0, 0, 0);
        end
        // Error accesses leave RAM unchanged (no aliasing of 0x400 onto word 0).
        tx(0, 1, 32'h0, 32'hA5A5_0000, 0, 0);
        tx(0, 1, 32'h100, 32'hCAFE_0100, 0, 0);
        tx(0, 1, 32'h102, 32'h1234_5678, 0, 0);
        tx(0, 0, 32'h400, 0, 0, 0);
        tx(0, 1, 32'h400, 32'hFFFF_FFFF, 0, 0);
        tx(0, 0, 32'h100, 0, 0, 0);
        tx(0, 0, 32'h0, 0, 0, 0);
        // Reset during WAIT abandons the store.
        tx(0, 1, 32'h20, 32'h1111_1111, 0, 0);
        tx(0, 1, 84, 7, 0, 0);
        we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'h55; req[0] = 1;
        @(posedge clk); #1;
        chk("a_wait1_ready", ready[0], 0);
        @(posedge clk); #1;
        chk("a_wait2_ready", ready[0], 0);
        rst_n = 0; req[0] = 0;
        model_reset();
        #1;
        chk("a_abort_state", 32'(u_a.r_state), 32'(IDLE));
        chk("a_abort_done", done[0], 0);
        chk("a_abort_pass", pass[0], 0);
        @(posedge clk); #1;
        rst_n = 1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ready[0]) extra++; end
        chk("a_abort_no_ready", extra, 0);
        tx(0, 0, 32'h20, 0, 0, 0);
        // Request dropped right after acceptance.
        tx(0, 0, 32'h10, 0, 1, 0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (ready[0]) extra++; end
        chk("a_drop_no_second", extra, 0);
        // Randomized traffic against the model.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 30; i++) begin
                case ($urandom_range(0, 9))
                    0: a = ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
                    1: a = $urandom_range(64, 100000) * 4;
                    2: a = 84;
                    default: a = $urandom_range(0, 63) * 4;
                endcase
                w = 1'($urandom_range(0, 1));
                d = (a == 84 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
                tx(u, w, a, d, 1'($urandom_range(0, 1)), (i < 29) && ($urandom_range(0, 1) == 1));
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the CPU data-memory bus: serves word loads/stores from the processor's memory stage after a programmable number of wait states, using a ready handshake.
- Contains a word-addressed RAM and a memory-mapped test mailbox. A CPU store of PASS_VALUE to MAILBOX_ADDR raises done/pass in hardware, which replaces the bench-side store watcher.
- Sits between the core's memory interface and the top-level, in place of a zero-latency dmem.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; legal word index 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, added wait states; legal range 0..15.
- MAILBOX_ADDR, 84, byte address of the status mailbox; must be word-aligned.
- PASS_VALUE, 7, value that marks a test pass when stored to the mailbox.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request valid; held high by the requester until ready.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  load data; valid while ready=1.
- err  out  1  error flag; valid while ready=1 (misaligned or out-of-range access).
- done  out  1  sticky: a store to the mailbox has occurred.
- pass  out  1  sticky: the last mailbox store equalled PASS_VALUE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ready, err, done and pass = 0; rdata=0; wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req=1 at an edge:
  - Latch we, addr and wdata.
  - Go to RESP if WAIT_CYCLES=0; otherwise go to WAIT with cnt=WAIT_CYCLES.
- WAIT: cnt decrements each edge. The edge with cnt=1 goes to RESP.
- Transition into RESP (the commit edge):
  - Decode uses the latched values.
  - RAM write or read happens on this edge; rdata, err, done and pass are registered on this edge.
- RESP: ready=1 for exactly one cycle, then IDLE.
- Latency: ready is high in the cycle after the (WAIT_CYCLES+1)th rising edge counted from the accepting edge (the accepting edge is edge 1).
- Decode order (latched address):
  1. addr[1:0]!=0 → err=1, rdata=0, no state change.
  2. addr==MAILBOX_ADDR:
     - Store: done<=1, pass<=(wdata==PASS_VALUE); RAM untouched.
     - Load: rdata={30'b0,pass,done} using the pre-edge values.
     - err=0.
  3. addr[31:2] >= DEPTH_WORDS → err=1, rdata=0, no write.
  4. Otherwise:
     - Store: ram[addr[31:2]]<=wdata, rdata=0.
     - Load: rdata=ram[addr[31:2]].
     - err=0.
- Outside RESP: ready=0. rdata and err are held at their last values and must be qualified by ready.
- req dropping after acceptance: the transaction still completes; inputs are not re-sampled until IDLE.
- req still high in the IDLE cycle after RESP: a new transaction is accepted using the current inputs (back-to-back). Minimum spacing is WAIT_CYCLES+2 cycles per access.
- done/pass:
  - Sticky until reset.
  - A later mailbox store updates pass (it can go from 1 to 0); done stays 1.
- Reset asserted mid-transaction: the transaction is abandoned immediately. If the commit edge has not occurred, the store is not performed. No ready pulse is issued after reset releases.
- Width rules: cnt is 4 bits; RAM index is $clog2(DEPTH_WORDS) bits; the range check uses the full addr[31:2] comparison (no aliasing).

Decomposition:
- Shared package mem_bus_pkg:
  - State enum {IDLE, WAIT, RESP}.
  - Constants WORD_BYTES=4 and ADDR_W=32.
  - Default MAILBOX_ADDR/PASS_VALUE values, so the benches and top use the same numbers.
- One natural sub-module: dmem_ram.
  - Single-port synchronous RAM with params DEPTH_WORDS, width 32.
  - Ports: clk, we, idx, wdata, rdata.
  - No reset.
- FSM, decode, counter and mailbox stay in dmem_responder.

Test Plan:
1. WAIT_CYCLES=2. Store addr=0x10, wdata=0xDEADBEEF, req held, then load addr=0x10 → each ready is a single pulse 3 edges after acceptance; load rdata=0xDEADBEEF, err=0.
2. WAIT_CYCLES=0. Back-to-back stores to 0x0, 0x4, 0x8 (values 1, 2, 3) with req held continuously, then loads → ready every 2nd cycle; readback 1, 2, 3.
3. Store addr=84, wdata=7 → done=1, pass=1. Then store addr=84, wdata=5 → done=1, pass=0. Load addr=84 → rdata=0x1.
4. Store addr=0x102 (misaligned) and load addr=0x400 (word 256 ≥ 64) → ready with err=1, rdata=0. A following load of 0x100 returns the value written previously; RAM is unchanged.
5. Store addr=0x20, wdata=0x55 accepted; reset pulsed low in the WAIT state before the commit edge → ready never pulses, done=pass=0, state=IDLE. Load 0x20 after reset returns the pre-reset RAM value (not 0x55).
6. req deasserted one cycle after acceptance of a load → ready still pulses at the nominal latency with correct rdata. No second transaction occurs.
